ntt_bf_scheduler: RTL and testbench

//  Sequences one forward Cooley-Tukey NTT (N=32, bit-reversed psi ordering) over a coefficient RAM.

---
 rtl/ntt_pkg.sv | 18 +
 rtl/ntt_addr_gen.sv | 33 +++
 rtl/ntt_bf_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ntt_bf_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the N=32 forward NTT butterfly scheduler.
package ntt_pkg;

    localparam int unsigned N       = 32;
    localparam int unsigned LOG_N   = 5;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned OUT_W   = 5;
    localparam int unsigned STAGE_W = 3;
    localparam int unsigned K_W     = LOG_N - 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } ntt_state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational Cooley-Tukey address map: (stage s, butterfly k) -> coefficient pair and psi index.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [STAGE_W-1:0] s,
    input  logic [K_W-1:0]     k,
    output logic [ADDR_W-1:0]  addr_a,
    output logic [ADDR_W-1:0]  addr_b,
    output logic [ADDR_W-1:0]  psi_addr
);

    logic [ADDR_W-1:0] kk;
    logic [ADDR_W-1:0] t;
    logic [ADDR_W-1:0] m;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] a;

    always_comb begin
        kk = {1'b0, k};
        t  = ADDR_W'(N >> (s + STAGE_W'(1)));
        m  = ADDR_W'(1) << s;
        // Group index i selects the twiddle; j is the offset inside the group.
        i  = kk >> (STAGE_W'(LOG_N - 1) - s);
        j  = kk & (t - ADDR_W'(1));
        // 2*i*t == i << (LOG_N - s), since 2*t == N >> s.
        a  = (i << (STAGE_W'(LOG_N) - s)) | j;
        addr_a   = a;
        addr_b   = a + t;
        psi_addr = m + i;
    end

endmodule

// File: rtl/ntt_bf_scheduler.sv
// Butterfly issue scheduler for one forward NTT; drains write-backs between stages.
// Optional stall_cnt performance counter is enabled by defining NTT_PERF_CNT_EN.
module ntt_bf_scheduler
    import ntt_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               bf_valid,
    input  logic               bf_ready,
    output logic [ADDR_W-1:0]  bf_addr_a,
    output logic [ADDR_W-1:0]  bf_addr_b,
    output logic [ADDR_W-1:0]  psi_addr,
    output logic [2:0]         bf_stage,
    input  logic               bf_wb,
    output logic               err
`ifdef NTT_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    ntt_state_e         state_q, state_d;
    logic [STAGE_W-1:0] s_q, s_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               err_q, err_d;
    logic               busy_q, done_q, valid_q;
    logic [ADDR_W-1:0]  addr_a_q, addr_b_q, psi_q;
    logic [ADDR_W-1:0]  gen_a, gen_b, gen_psi;
    logic               fire;

    assign fire = valid_q & bf_ready;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            StIssue: begin
                if (fire) begin
                    if (k_q == K_W'(N / 2 - 1)) begin
                        k_d     = '0;
                        state_d = StDrain;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            StDrain: begin
                // Next stage reads what this stage wrote, so wait for every write-back.
                if (out_q == '0) begin
                    if (s_q == STAGE_W'(LOG_N - 1)) begin
                        state_d = StDone;
                    end else begin
                        s_d     = s_q + STAGE_W'(1);
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                s_d     = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        out_d = out_q;
        err_d = err_q;
        case ({fire, bf_wb})
            2'b10: out_d = out_q + OUT_W'(1);
            2'b01: begin
                if (out_q != '0) begin
                    out_d = out_q - OUT_W'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            default: out_d = out_q;
        endcase
    end

    // Addresses are generated from next-state counters so the request registers line up with s/k.
    ntt_addr_gen u_addr_gen (
        .s        (s_d),
        .k        (k_d),
        .addr_a   (gen_a),
        .addr_b   (gen_b),
        .psi_addr (gen_psi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            s_q      <= '0;
            k_q      <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            psi_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            out_q   <= out_d;
            err_q   <= err_d;
            busy_q  <= (state_d == StIssue) || (state_d == StDrain);
            done_q  <= (state_d == StDone);
            valid_q <= (state_d == StIssue);
            if (state_d == StIssue) begin
                addr_a_q <= gen_a;
                addr_b_q <= gen_b;
                psi_q    <= gen_psi;
            end else if (state_d == StIdle) begin
                addr_a_q <= '0;
                addr_b_q <= '0;
                psi_q    <= '0;
            end
        end
    end

`ifdef NTT_PERF_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == StIdle) && start) begin
            stall_d = '0;
        end else if (valid_q && !bf_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign bf_valid  = valid_q;
    assign bf_addr_a = addr_a_q;
    assign bf_addr_b = addr_b_q;
    assign psi_addr  = psi_q;
    assign bf_stage  = s_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Directed bench for ntt_bf_scheduler: vector table of issued butterflies plus multi-cycle sequences.
module tb_ntt_bf_scheduler;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       bf_valid;
    logic       bf_ready;
    logic [4:0] bf_addr_a;
    logic [4:0] bf_addr_b;
    logic [4:0] psi_addr;
    logic [2:0] bf_stage;
    logic       bf_wb;
    logic       err;
`ifdef NTT_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    ntt_bf_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .bf_valid  (bf_valid),
        .bf_ready  (bf_ready),
        .bf_addr_a (bf_addr_a),
        .bf_addr_b (bf_addr_b),
        .psi_addr  (psi_addr),
        .bf_stage  (bf_stage),
        .bf_wb     (bf_wb),
        .err       (err)
`ifdef NTT_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int stage;
        int a;
        int b;
        int psi;
    } vec_t;

    vec_t vecs [13];

    int n_vec = 0;
    int n_bad = 0;

    // Recorded fires and the reference sequence from the textbook loop nest.
    int fa [96];
    int fb [96];
    int fp [96];
    int fs [96];
    int ea [80];
    int eb [80];
    int ep [80];
    int es [80];

    int nf, dcyc, dcnt, sbad;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        bf_ready = 1'b0;
        bf_wb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic build_model();
        int n;
        n = 0;
        for (int s = 0; s < 5; s++) begin
            int m;
            int t;
            m = 1 << s;
            t = 32 >> (s + 1);
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < t; j++) begin
                    ea[n] = 2 * i * t + j;
                    eb[n] = ea[n] + t;
                    ep[n] = m + i;
                    es[n] = s;
                    n++;
                end
            end
        end
    endtask

    task automatic check_seq(input string name, input int count);
        int bad;
        bad = 0;
        for (int n = 0; n < 80; n++) begin
            if (n >= count || fa[n] != ea[n] || fb[n] != eb[n] || fp[n] != ep[n] ||
                fs[n] != es[n]) begin
                bad++;
            end
        end
        chk(name, bad, 0);
    endtask

    // Full transform from IDLE; wb follows each fire by one cycle. Cycle 1 = first cycle after start.
    task automatic run_transform(input bit rnd, input int start_again, output int o_nf,
                                 output int o_dcyc, output int o_dcnt, output int o_sbad);
        bit         pend;
        bit         stalled;
        logic [4:0] pa, pb, pp;
        logic [2:0] ps;
        o_nf = 0;
        o_dcyc = -1;
        o_dcnt = 0;
        o_sbad = 0;
        pend = 1'b0;
        stalled = 1'b0;
        pa = '0;
        pb = '0;
        pp = '0;
        ps = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (stalled && (!bf_valid || bf_addr_a != pa || bf_addr_b != pb ||
                            psi_addr != pp || bf_stage != ps)) begin
                o_sbad++;
            end
            if (done) begin
                o_dcnt++;
                if (o_dcyc < 0) o_dcyc = cyc;
            end
            bf_wb = pend;
            bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (cyc == start_again);
            pend = bf_valid && bf_ready;
            stalled = bf_valid && !bf_ready;
            pa = bf_addr_a;
            pb = bf_addr_b;
            pp = psi_addr;
            ps = bf_stage;
            if (pend && o_nf < 96) begin
                fa[o_nf] = int'(bf_addr_a);
                fb[o_nf] = int'(bf_addr_b);
                fp[o_nf] = int'(psi_addr);
                fs[o_nf] = int'(bf_stage);
                o_nf++;
            end
            if (o_dcyc > 0 && cyc >= o_dcyc + 2) break;
            @(negedge clk);
        end
        bf_wb = 1'b0;
        bf_ready = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int c;
        int bad;
        int cnt;
        bit pend;

        vecs[0]  = '{0,  0, 0,  16, 1};
        vecs[1]  = '{1,  0, 1,  17, 1};
        vecs[2]  = '{15, 0, 15, 31, 1};
        vecs[3]  = '{16, 1, 0,  8,  2};
        vecs[4]  = '{24, 1, 16, 24, 3};
        vecs[5]  = '{31, 1, 23, 31, 3};
        vecs[6]  = '{32, 2, 0,  4,  4};
        vecs[7]  = '{37, 2, 9,  13, 5};
        vecs[8]  = '{48, 3, 0,  2,  8};
        vecs[9]  = '{53, 3, 9,  11, 10};
        vecs[10] = '{64, 4, 0,  1,  16};
        vecs[11] = '{70, 4, 12, 13, 22};
        vecs[12] = '{79, 4, 30, 31, 31};

        build_model();
        rst = 1'b1;
        start = 1'b0;
        bf_ready = 1'b0;
        bf_wb = 1'b0;
        do_reset();

        // Reset state
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(bf_valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_addr_a", int'(bf_addr_a), 0);
        chk("rst_addr_b", int'(bf_addr_b), 0);
        chk("rst_psi", int'(psi_addr), 0);
        chk("rst_stage", int'(bf_stage), 0);
`ifdef NTT_PERF_CNT_EN
        chk("rst_stall_cnt", int'(stall_cnt), 0);
`endif

        // First request one cycle after start
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("c1_valid", int'(bf_valid), 1);
        chk("c1_busy", int'(busy), 1);
        chk("c1_addr_a", int'(bf_addr_a), 0);
        chk("c1_addr_b", int'(bf_addr_b), 16);
        chk("c1_psi", int'(psi_addr), 1);
        chk("c1_stage", int'(bf_stage), 0);
        do_reset();

        // Full-rate transform
        run_transform(1'b0, 0, nf, dcyc, dcnt, sbad);
        chk("full_fires", nf, 80);
        chk("full_done_cycle", dcyc, 91);
        chk("full_done_pulses", dcnt, 1);
        chk("full_err", int'(err), 0);
        for (int v = 0; v < 13; v++) begin
            int act;
            int exp;
            act = fs[vecs[v].idx] * 1000000 + fa[vecs[v].idx] * 10000 +
                  fb[vecs[v].idx] * 100 + fp[vecs[v].idx];
            exp = vecs[v].stage * 1000000 + vecs[v].a * 10000 + vecs[v].b * 100 + vecs[v].psi;
            chk($sformatf("fire%0d_stage_a_b_psi", vecs[v].idx), act, exp);
        end
        check_seq("full_sequence", nf);

        // Random backpressure
        run_transform(1'b1, 0, nf, dcyc, dcnt, sbad);
        chk("bp_fires", nf, 80);
        chk("bp_done_pulses", dcnt, 1);
        chk("bp_stall_stable", sbad, 0);
        chk("bp_err", int'(err), 0);
        check_seq("bp_sequence", nf);

        // Withheld write-backs hold the FSM in DRAIN
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bf_ready = 1'b1;
        cnt = 0;
        for (c = 0; c < 40; c++) begin
            if (cnt >= 16) break;
            if (bf_valid) cnt++;
            @(negedge clk);
        end
        chk("drain_fires", cnt, 16);
        bad = 0;
        repeat (10) begin
            if (bf_valid || !busy || bf_stage != 3'd0) bad++;
            @(negedge clk);
        end
        chk("drain_hold", bad, 0);
        bad = 0;
        repeat (16) begin
            if (bf_valid) bad++;
            bf_wb = 1'b1;
            @(negedge clk);
        end
        bf_wb = 1'b0;
        chk("drain_release_no_early_issue", bad, 0);
        for (c = 0; c < 5; c++) begin
            if (bf_valid) break;
            @(negedge clk);
        end
        chk("drain_stage1_valid", int'(bf_valid), 1);
        chk("drain_stage1_stage", int'(bf_stage), 1);
        chk("drain_stage1_a_b_psi",
            int'(bf_addr_a) * 10000 + int'(bf_addr_b) * 100 + int'(psi_addr), 802);
        chk("drain_err", int'(err), 0);

        // Reset mid stage 2
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        pend = 1'b0;
        for (c = 0; c < 200; c++) begin
            bf_wb = pend;
            bf_ready = 1'b1;
            pend = bf_valid;
            if (bf_valid) cnt++;
            @(negedge clk);
            if (cnt >= 37) break;
        end
        chk("abort_in_stage2", int'(bf_stage), 2);
        rst = 1'b1;
        bf_wb = 1'b0;
        bf_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs_zero",
            int'({busy, done, bf_valid, err, bf_addr_a, bf_addr_b, psi_addr, bf_stage}), 0);
        bad = 0;
        repeat (3) begin
            if (done || busy) bad++;
            @(negedge clk);
        end
        chk("abort_no_done", bad, 0);
        bf_wb = 1'b1;
        @(negedge clk);
        bf_wb = 1'b0;
        chk("abort_late_wb_err", int'(err), 1);
        do_reset();
        chk("abort_err_cleared", int'(err), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_c1", int'(bf_valid) * 10000 + int'(bf_addr_a) * 100 + int'(psi_addr), 10001);
        do_reset();

        // Spurious wb in IDLE; start while busy ignored
        bf_wb = 1'b1;
        @(negedge clk);
        bf_wb = 1'b0;
        chk("spurious_wb_err", int'(err), 1);
        repeat (3) @(negedge clk);
        chk("spurious_wb_err_sticky", int'(err), 1);
        run_transform(1'b0, 40, nf, dcyc, dcnt, sbad);
        chk("restart_ignored_fires", nf, 80);
        chk("restart_ignored_done_cycle", dcyc, 91);
        check_seq("restart_ignored_sequence", nf);
        chk("err_sticky_after_run", int'(err), 1);

`ifdef NTT_PERF_CNT_EN
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bf_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_cnt_3", int'(stall_cnt), 3);
        do_reset();
        chk("stall_cnt_rst", int'(stall_cnt), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
